// File: rtl/mi_loader.sv
// mi_loader: boot-time owner of the instruction memory port. Receives a
// byte-streamed program (count byte, then words MSB first), writes it from
// address 0 upward, then hands the port to the fetch path and raises cpu_run.
module mi_loader #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              reload,
   input  logic [31:0]       cpu_addr,
   output logic [DATA_W-1:0] cpu_instr,
   output logic              cpu_run,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              err
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned BYTES = DATA_W / 8;
   // One extra bit so the count N=DEPTH and the post-increment address fit.
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned BC_W  = $clog2(BYTES + 1);

   typedef enum logic [2:0] {
      S_COUNT,
      S_BYTE,
      S_WRITE,
      S_RUN,
      S_ERR
   } state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  waddr;
   logic [CNT_W-1:0]  words_left;
   logic [BC_W-1:0]   byte_cnt;
   logic [DATA_W-1:0] shift;

   logic take;
   logic n_zero;
   logic n_big;
   logic last_byte;

   assign take      = rx_valid && rx_ready;
   assign n_zero    = (rx_data == 8'd0);
   assign n_big     = (32'(rx_data) > DEPTH);
   assign last_byte = (byte_cnt == BC_W'(BYTES - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_COUNT;
      else        state <= state_n;
   end

   // Load datapath: word counter, write address, byte counter, shifter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waddr      <= '0;
         words_left <= '0;
         byte_cnt   <= '0;
         shift      <= '0;
      end else if (reload) begin
         waddr      <= '0;
         words_left <= '0;
         byte_cnt   <= '0;
         shift      <= '0;
      end else begin
         case (state)
            S_COUNT: begin
               if (take && !n_zero && !n_big) begin
                  words_left <= CNT_W'(rx_data);
                  waddr      <= '0;
                  byte_cnt   <= '0;
               end
            end
            S_BYTE: begin
               if (take) begin
                  // Drop the oldest byte, append the new one at the LSB end.
                  shift    <= DATA_W'({shift, rx_data});
                  byte_cnt <= byte_cnt + BC_W'(1);
               end
            end
            S_WRITE: begin
               waddr      <= waddr + CNT_W'(1);
               words_left <= words_left - CNT_W'(1);
               byte_cnt   <= '0;
            end
            default: ;
         endcase
      end
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      state_n   = state;
      rx_ready  = 1'b0;
      busy      = 1'b0;
      err       = 1'b0;
      cpu_run   = 1'b0;
      cpu_instr = '0;
      mem_we    = 1'b0;
      mem_addr  = waddr[ADDR_W-1:0];
      mem_wdata = '0;

      case (state)
         S_COUNT: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (take) begin
               if (n_zero)     state_n = S_RUN;
               else if (n_big) state_n = S_ERR;
               else            state_n = S_BYTE;
            end
         end
         S_BYTE: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (take && last_byte) state_n = S_WRITE;
         end
         S_WRITE: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = shift;
            if (words_left == CNT_W'(1)) state_n = S_RUN;
            else                         state_n = S_BYTE;
         end
         S_RUN: begin
            cpu_run  = 1'b1;
            mem_addr = cpu_addr[ADDR_W-1:0];
            if ((cpu_addr >> ADDR_W) == '0) cpu_instr = mem_rdata;
         end
         S_ERR: begin
            err = 1'b1;
         end
         default: state_n = S_COUNT;
      endcase

      // Reload wins over every transition; an S_WRITE strobe above still fires.
      if (reload) state_n = S_COUNT;
   end

endmodule

// File: tb/tb_mi_loader.sv
// Directed bench for mi_loader with a behavioural instruction memory.
module tb_mi_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        reload;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_instr;
   logic        cpu_run;
   logic [4:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        err;

   logic [31:0] mem [32];
   int          n_vec = 0;
   int          n_bad = 0;
   int          wr_cnt = 0;
   int          n_taken = 0;
   int          exp_taken = 0;

   always #5 clk = ~clk;

   mi_loader #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .reload(reload), .cpu_addr(cpu_addr),
      .cpu_instr(cpu_instr), .cpu_run(cpu_run), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .err(err)
   );

   assign mem_rdata = mem[mem_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory array model and handshake counter.
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wr_cnt++;
      end
      if (rst_n && rx_valid && rx_ready && !reload) n_taken++;
   end

   // The loader must never accept a byte during its write cycle.
   always @(negedge clk) begin
      if (mem_we) check("rdy_in_write", {31'b0, rx_ready}, 32'd0);
   end

   function automatic logic [31:0] pat(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b ^ 8'h5A, 8'hC3, b, 8'h3C};
   endfunction

   // Entered between edges; returns at the negedge after the byte is taken.
   task automatic send_byte(input logic [7:0] d);
      bit done;
      done = 0;
      rx_valid = 1'b1;
      rx_data  = d;
      for (int k = 0; k < 20 && !done; k++) begin
         if (rx_ready) begin
            @(posedge clk);
            @(negedge clk);
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      rx_valid = 1'b0;
      rx_data  = 8'hEE;
      if (done) exp_taken++;
      else check("rx_ready_wait", {31'b0, rx_ready}, 32'd1);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int b = 0; b < 4; b++) begin
         send_byte(w[31-8*b -: 8]);
         if (b < 3) repeat (gap) @(negedge clk);
      end
   endtask

   task automatic do_reload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   int w0;

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; reload = 1'b0; cpu_addr = '0;
      #12;
      check("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
      check("rst_busy",     {31'b0, busy},     32'd1);
      check("rst_cpu_run",  {31'b0, cpu_run},  32'd0);
      check("rst_err",      {31'b0, err},      32'd0);
      check("rst_mem_we",   {31'b0, mem_we},   32'd0);
      check("rst_mem_addr", {27'b0, mem_addr}, 32'd0);
      check("rst_wdata",    mem_wdata,         32'd0);
      check("rst_instr",    cpu_instr,         32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Two-word program, back-to-back bytes.
      send_byte(8'd2);
      send_word(32'h14000000, 0);
      check("w0_we",   {31'b0, mem_we},   32'd1);
      check("w0_addr", {27'b0, mem_addr}, 32'd0);
      check("w0_data", mem_wdata,         32'h14000000);
      send_word(32'h40000000, 0);
      check("w1_we",   {31'b0, mem_we},   32'd1);
      check("w1_addr", {27'b0, mem_addr}, 32'd1);
      check("w1_data", mem_wdata,         32'h40000000);
      check("w1_run",  {31'b0, cpu_run},  32'd0);
      @(negedge clk);
      check("run1",      {31'b0, cpu_run}, 32'd1);
      check("run1_busy", {31'b0, busy},    32'd0);
      cpu_addr = 32'd1;
      #1 check("fetch1", cpu_instr, 32'h40000000);

      // Same program with rx_valid gaps of 0..3 cycles.
      do_reload();
      check("rl_run",   {31'b0, cpu_run}, 32'd0);
      check("rl_busy",  {31'b0, busy},    32'd1);
      check("rl_instr", cpu_instr,        32'd0);
      mem[0] = '0; mem[1] = '0;
      n_taken = 0; exp_taken = 0; w0 = wr_cnt;
      send_byte(8'd2);
      repeat (3) @(negedge clk);
      send_word(32'h14000000, 1);
      repeat (2) @(negedge clk);
      send_word(32'h40000000, 3);
      @(negedge clk);
      check("gap_mem0",  mem[0],      32'h14000000);
      check("gap_mem1",  mem[1],      32'h40000000);
      check("gap_wr",    wr_cnt - w0, 32'd2);
      check("gap_taken", n_taken,     exp_taken);
      check("gap_nbyte", n_taken,     32'd9);
      check("gap_run",   {31'b0, cpu_run}, 32'd1);

      // N=0: straight to run, no write.
      do_reload();
      w0 = wr_cnt;
      send_byte(8'd0);
      check("n0_run", {31'b0, cpu_run}, 32'd1);
      check("n0_wr",  wr_cnt - w0,      32'd0);

      // N=32: full memory.
      do_reload();
      for (int i = 0; i < 32; i++) mem[i] = '0;
      w0 = wr_cnt;
      send_byte(8'd32);
      for (int i = 0; i < 32; i++) send_word(pat(i), 0);
      @(negedge clk);
      check("n32_wr",  wr_cnt - w0,      32'd32);
      check("n32_run", {31'b0, cpu_run}, 32'd1);
      for (int i = 0; i < 32; i++) check($sformatf("n32_mem%0d", i), mem[i], pat(i));

      // N=33: error, no writes, reload clears it.
      do_reload();
      w0 = wr_cnt;
      send_byte(8'd33);
      check("n33_err",   {31'b0, err},      32'd1);
      check("n33_rdy",   {31'b0, rx_ready}, 32'd0);
      check("n33_busy",  {31'b0, busy},     32'd0);
      check("n33_run",   {31'b0, cpu_run},  32'd0);
      rx_valid = 1'b1; rx_data = 8'h01;
      repeat (3) @(negedge clk);
      rx_valid = 1'b0;
      check("n33_wr",    wr_cnt - w0,       32'd0);
      check("n33_hold",  {31'b0, err},      32'd1);
      do_reload();
      check("n33_clr",   {31'b0, err},      32'd0);
      check("n33_rdy2",  {31'b0, rx_ready}, 32'd1);

      // A byte presented together with reload is discarded.
      rx_valid = 1'b1; rx_data = 8'd5;
      do_reload();
      rx_valid = 1'b0;
      send_byte(8'd0);
      check("rl_byte_drop", {31'b0, cpu_run}, 32'd1);

      // Run-mode fetch boundary, then reload and a one-word overwrite.
      cpu_addr = 32'd40;
      #1 check("fetch_oob", cpu_instr, 32'd0);
      cpu_addr = 32'd5;
      #1 check("fetch5", cpu_instr, pat(5));
      @(negedge clk);
      do_reload();
      check("rl2_run",   {31'b0, cpu_run}, 32'd0);
      check("rl2_instr", cpu_instr,        32'd0);
      check("rl2_busy",  {31'b0, busy},    32'd1);
      w0 = wr_cnt;
      send_byte(8'd1);
      send_word(32'hDEADBEEF, 0);
      @(negedge clk);
      check("n1_wr",   wr_cnt - w0,      32'd1);
      check("n1_mem0", mem[0],           32'hDEADBEEF);
      check("n1_mem1", mem[1],           pat(1));
      check("n1_run",  {31'b0, cpu_run}, 32'd1);

      // Asynchronous reset after two bytes of the third word.
      do_reload();
      send_byte(8'd4);
      send_word(32'hA1A2A3A4, 0);
      send_word(32'hB1B2B3B4, 0);
      send_byte(8'hC1);
      send_byte(8'hC2);
      #2 rst_n = 1'b0;
      #1;
      check("ar_rdy",   {31'b0, rx_ready}, 32'd1);
      check("ar_busy",  {31'b0, busy},     32'd1);
      check("ar_we",    {31'b0, mem_we},   32'd0);
      check("ar_addr",  {27'b0, mem_addr}, 32'd0);
      check("ar_wdata", mem_wdata,         32'd0);
      check("ar_run",   {31'b0, cpu_run},  32'd0);
      check("ar_err",   {31'b0, err},      32'd0);
      check("ar_mem1",  mem[1],            32'hB1B2B3B4);
      @(negedge clk);
      rst_n = 1'b1;
      w0 = wr_cnt;
      send_byte(8'd1);
      send_word(32'h11223344, 2);
      check("ar_w_we",   {31'b0, mem_we},   32'd1);
      check("ar_w_addr", {27'b0, mem_addr}, 32'd0);
      check("ar_w_data", mem_wdata,         32'h11223344);
      @(negedge clk);
      check("ar_w_cnt",  wr_cnt - w0,      32'd1);
      check("ar_mem2",   mem[2],           pat(2));
      check("ar_run2",   {31'b0, cpu_run}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
